// File: rtl/rr_fifo_arbiter_param_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb_pkg
// Brief   : Shared constants and width helpers for the round-robin FIFO
//           arbiter slice.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package rr_arb_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_SKIP_EMPTY = 1;

  // Widest channel index ever needed (16 channels)
  localparam int MAX_CH_W = 4;
  typedef logic [MAX_CH_W-1:0] ch_idx_t;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Channel index width; never narrower than one bit
  function automatic int ch_w(input int num_ch);
    return (num_ch < 2) ? 1 : clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_fifo_arbiter_param_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_fifo_arbiter_param_if
// Brief   : Producer/consumer bundle of the round-robin FIFO arbiter.
//           slave = arbiter side, master = environment side.
// Revision: 1.0 - initial parametrised release
// ============================================================================
interface rr_fifo_arbiter_param_if
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]        wen;
  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        overflow;
  logic                     ready;
  logic                     valid;
  logic [DATA_W-1:0]        dout;
  logic [CH_W-1:0]          dout_ch;

  modport slave  (input  wen, din, ready,
                  output full, overflow, valid, dout, dout_ch);
  modport master (output wen, din, ready,
                  input  full, overflow, valid, dout, dout_ch);
endinterface
`default_nettype wire

// File: rtl/rr_fifo_arbiter_param_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rr_chan_fifo
// Brief   : One channel FIFO with combinational head, occupancy count,
//           full flag and a one-cycle overflow pulse for dropped writes.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module rr_chan_fifo
  import rr_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push, pop_ok;

  // Full is judged on the start-of-cycle count, so a same-cycle pop
  // never rescues a write into a full FIFO.
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign push       = wen_i && !full_o;
  assign pop_ok     = pop_i && (count_q != '0);
  assign dout_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  // Next pointers, occupancy and overflow pulse
  always_comb begin
    wr_ptr_d   = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = wen_i && full_o;
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/rr_fifo_arbiter_param.sv
`default_nettype none
// ============================================================================
// Module  : rr_fifo_arbiter_param
// Brief   : NUM_CH channel FIFOs merged onto one registered valid/ready
//           output by a round-robin grant (work-conserving or strict slots).
// Revision: 1.0 - initial parametrised release
// ============================================================================
module rr_fifo_arbiter_param
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SKIP_EMPTY = DEF_SKIP_EMPTY
) (
  input  logic clk,
  input  logic rst_n,
  rr_fifo_arbiter_param_if.slave bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head  [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] pop;

  logic              load, found;
  logic [CH_W-1:0]   grant, grant_next;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    rr_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wen_i      (bus.wen[i]),
      .pop_i      (pop[i]),
      .din_i      (bus.din[i*DATA_W +: DATA_W]),
      .dout_o     (head[i]),
      .count_o    (count[i]),
      .full_o     (bus.full[i]),
      .overflow_o (bus.overflow[i])
    );
    assign nonempty[i] = (count[i] != '0);
  end

  // A new word may be loaded when the output stage is empty or draining
  assign load = !valid_q || bus.ready;

  if (SKIP_EMPTY != 0) begin : g_skip
    // First non-empty channel at or after the pointer, wrapping
    always_comb begin
      int              idx;
      logic [CH_W-1:0] cand;
      idx   = 0;
      cand  = '0;
      found = 1'b0;
      grant = ptr_q;
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        cand = CH_W'(idx);
        if (!found && nonempty[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end else begin : g_strict
    // Fixed slot: the pointed channel or nothing
    assign grant = ptr_q;
    assign found = nonempty[ptr_q];
  end

  assign grant_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

  // Pop strobes, pointer advance and output-stage next state
  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = load && found && (grant == CH_W'(i));
    end
    if (load) begin
      valid_d = found;
      if (found) begin
        dout_d = head[grant];
        ch_d   = grant;
      end
      // Strict mode burns the slot even when it is empty
      if (found || (SKIP_EMPTY == 0)) ptr_d = grant_next;
    end
  end

  // Grant pointer and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ch_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.dout    = dout_q;
  assign bus.dout_ch = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_fifo_arbiter_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_fifo_arbiter_param
// Brief   : Drives a work-conserving and a strict-slot arbiter with the same
//           stimulus; a queue-based reference model fills per-instance
//           scoreboards that a negedge monitor drains and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_fifo_arbiter_param;
  import rr_arb_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        wen;
  logic [NUM_CH*DATA_W-1:0] din;
  logic                     ready;

  int checks   = 0;
  int failures = 0;

  rr_fifo_arbiter_param_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus0 ();
  rr_fifo_arbiter_param_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus1 ();

  assign bus0.wen = wen;  assign bus0.din = din;  assign bus0.ready = ready;
  assign bus1.wen = wen;  assign bus1.din = din;  assign bus1.ready = ready;

  rr_fifo_arbiter_param #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP_EMPTY(1))
    u_skip (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rr_fifo_arbiter_param #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP_EMPTY(0))
    u_strict (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Per-instance views of the outputs (0 = skip-empty, 1 = strict)
  logic              d_valid [2];
  logic [DATA_W-1:0] d_dout  [2];
  logic [CH_W-1:0]   d_ch    [2];
  logic [NUM_CH-1:0] d_full  [2];
  logic [NUM_CH-1:0] d_ovf   [2];
  assign d_valid[0] = bus0.valid;    assign d_valid[1] = bus1.valid;
  assign d_dout[0]  = bus0.dout;     assign d_dout[1]  = bus1.dout;
  assign d_ch[0]    = bus0.dout_ch;  assign d_ch[1]    = bus1.dout_ch;
  assign d_full[0]  = bus0.full;     assign d_full[1]  = bus1.full;
  assign d_ovf[0]   = bus0.overflow; assign d_ovf[1]   = bus1.overflow;

  task automatic chk(input bit ok, input string nm, input int m,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d got=0x%0h want=0x%0h t=%0t", nm, m, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                mq [2*NUM_CH][$];   // channel contents per instance
  int                exp_q [2][$];       // words the output must present, in order
  int                mptr [2];
  bit                mvalid [2];
  logic [NUM_CH-1:0] movf [2];

  always @(posedge clk or negedge rst_n) begin : model
    int sz [NUM_CH];
    int g, c, word;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < NUM_CH; k++) mq[m*NUM_CH+k].delete();
        exp_q[m].delete();
        mptr[m]   = 0;
        mvalid[m] = 1'b0;
        movf[m]   = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < NUM_CH; k++) sz[k] = mq[m*NUM_CH+k].size();
        movf[m] = '0;
        if (!mvalid[m] || ready) begin
          g = -1;
          if (m == 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
              c = (mptr[m] + k) % NUM_CH;
              if (g < 0 && sz[c] > 0) g = c;
            end
            if (g >= 0) mptr[m] = (g + 1) % NUM_CH;
          end else begin
            c = mptr[m];
            mptr[m] = (mptr[m] + 1) % NUM_CH;
            if (sz[c] > 0) g = c;
          end
          if (g >= 0) begin
            word = mq[m*NUM_CH+g].pop_front();
            exp_q[m].push_back((g << DATA_W) | word);
            mvalid[m] = 1'b1;
          end else begin
            mvalid[m] = 1'b0;
          end
        end
        for (int k = 0; k < NUM_CH; k++) begin
          if (wen[k]) begin
            if (sz[k] == DEPTH) movf[m][k] = 1'b1;
            else mq[m*NUM_CH+k].push_back(int'(din[k*DATA_W +: DATA_W]));
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit   prev_valid [2];
  bit   prev_ready;
  logic [CH_W+DATA_W-1:0] held [2];

  always @(negedge clk) begin : monitor
    int                e;
    ch_idx_t           ech;
    logic [NUM_CH-1:0] ef;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        chk(!d_valid[m] && d_dout[m] == '0 && d_ch[m] == '0 && d_full[m] == '0 && d_ovf[m] == '0,
            "reset_outputs", m, {d_valid[m], d_ch[m], d_dout[m], d_full[m], d_ovf[m]}, 0);
        prev_valid[m] = 1'b0;
      end else begin
        for (int k = 0; k < NUM_CH; k++) ef[k] = (mq[m*NUM_CH+k].size() == DEPTH);
        chk(d_valid[m] == mvalid[m], "valid", m, d_valid[m], mvalid[m]);
        chk(d_full[m] == ef, "full", m, d_full[m], ef);
        chk(d_ovf[m] == movf[m], "overflow", m, d_ovf[m], movf[m]);
        if (d_valid[m]) begin
          if (!prev_valid[m] || prev_ready) begin
            if (exp_q[m].size() == 0) begin
              chk(1'b0, "unexpected_word", m, {d_ch[m], d_dout[m]}, 0);
            end else begin
              e   = exp_q[m].pop_front();
              ech = ch_idx_t'(e >> DATA_W);
              chk(d_ch[m] == ech[CH_W-1:0], "dout_ch", m, d_ch[m], ech);
              chk(d_dout[m] == DATA_W'(e), "dout", m, d_dout[m], e & 8'hFF);
            end
          end else begin
            chk({d_ch[m], d_dout[m]} == held[m], "hold_stable", m, {d_ch[m], d_dout[m]}, held[m]);
          end
          held[m] = {d_ch[m], d_dout[m]};
        end
        prev_valid[m] = d_valid[m];
      end
    end
    prev_ready = ready;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [NUM_CH-1:0] w, input logic [NUM_CH*DATA_W-1:0] d, input logic r);
    @(posedge clk); #1;
    wen = w; din = d; ready = r;
  endtask

  task automatic wr1(input int ch, input logic [DATA_W-1:0] v, input logic r);
    logic [NUM_CH*DATA_W-1:0] d;
    d = '0;
    d[ch*DATA_W +: DATA_W] = v;
    cyc(NUM_CH'(1) << ch, d, r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc('0, '0, r);
  endtask

  initial begin
    logic [NUM_CH*DATA_W-1:0] rd;
    logic [NUM_CH-1:0]        rw;
    int                       wp, rp;
    rst_n = 1'b0; wen = '0; din = '0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle, then single-word latency on channel 2
    idle(3, 1'b1);
    wr1(2, 8'h11, 1'b1);
    idle(4, 1'b1);

    // Preload ch0={A0,A1}, ch1={B0}, ch3={D0,D1}, then drain
    cyc(4'b1011, {8'hD0, 8'h00, 8'hB0, 8'hA0}, 1'b0);
    cyc(4'b1001, {8'hD1, 8'h00, 8'h00, 8'hA1}, 1'b0);
    idle(12, 1'b1);

    // Fill ch1 past capacity, hold backpressure, then release
    for (int i = 0; i < 9; i++) wr1(1, DATA_W'(8'h21 + i), 1'b0);
    wr1(1, 8'hFF, 1'b0);
    idle(5, 1'b0);
    idle(15, 1'b1);

    // Reset mid-stream with ch0 holding data
    for (int i = 0; i < 3; i++) wr1(0, DATA_W'(8'h51 + i), 1'b0);
    idle(1, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0; wen = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr1(3, 8'h33, 1'b1);
    idle(5, 1'b1);

    // Randomised traffic in three load regimes
    for (int i = 0; i < 3000; i++) begin
      case ((i / 200) % 3)
        0:       begin wp = 30; rp = 75; end
        1:       begin wp = 70; rp = 25; end
        default: begin wp = 10; rp = 90; end
      endcase
      for (int k = 0; k < NUM_CH; k++) begin
        rw[k] = ($urandom_range(0, 99) < wp);
        rd[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      cyc(rw, rd, $urandom_range(0, 99) < rp);
    end

    // Drain and confirm every predicted word was seen
    idle(60, 1'b1);
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      chk(exp_q[m].size() == 0, "scoreboard_drained", m, exp_q[m].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
